// File: rtl/dla_ofmap_writer.sv
// Output-feature-map writer: packs pairs of 16-bit results into 32-bit words,
// buffers them in a small FIFO and writes them out over a req/ack port.
module dla_ofmap_writer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_words,
    input  logic              in_valid,
    input  logic [15:0]       in_data,
    input  logic              flush,
    output logic              stall,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_strb,
    input  logic              wr_ack,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] num_q;
    logic [ADDR_W-1:0] pushed_q;
    logic [ADDR_W-1:0] written_q;
    logic              half_pending;
    logic [15:0]       low_q;

    logic [31:0]   mem_data [DEPTH];
    logic [3:0]    mem_strb [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;

    logic        fifo_full;
    logic        fifo_empty;
    logic        all_pushed;
    logic        in_run;
    logic        accept;
    logic        push_pair;
    logic        push_flush;
    logic        push;
    logic        pop;
    logic        drained;
    logic        job_start;
    logic [31:0] push_data;
    logic [3:0]  push_strb;

    // Handshakes: an input halfword transfers on in_valid && !stall; a write
    // transfers on wr_req && wr_ack, and wr_addr/wr_data/wr_strb hold until then.
    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign all_pushed = (pushed_q == num_q);
    assign in_run     = (state == S_RUN);

    assign stall      = !in_run || all_pushed || (fifo_full && half_pending);
    assign accept     = in_valid && !stall;
    assign push_pair  = accept && half_pending;
    assign push_flush = flush && !accept && in_run && !all_pushed && half_pending && !fifo_full;
    assign push       = push_pair || push_flush;
    assign push_data  = push_pair ? {in_data, low_q} : {16'h0000, low_q};
    assign push_strb  = push_pair ? 4'b1111 : 4'b0011;

    assign wr_req  = !fifo_empty;
    assign pop     = wr_req && wr_ack;
    assign wr_data = mem_data[rptr];
    assign wr_strb = mem_strb[rptr];
    assign wr_addr = base_q + (written_q << 2);

    // True when the FIFO is empty after this edge, so DONE follows the last ack directly.
    assign drained   = fifo_empty || ((count == ONE_CNT) && pop && !push);
    assign job_start = (state == S_IDLE) && start;

    assign busy      = (state == S_RUN) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (num_words == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (all_pushed) begin
                    state_nx = drained ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drained) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q       <= '0;
            num_q        <= '0;
            pushed_q     <= '0;
            written_q    <= '0;
            half_pending <= 1'b0;
            low_q        <= '0;
        end else if (job_start) begin
            base_q       <= base_addr;
            num_q        <= num_words;
            pushed_q     <= '0;
            written_q    <= '0;
            half_pending <= 1'b0;
        end else begin
            if (push) begin
                pushed_q <= pushed_q + 1'b1;
            end
            if (pop) begin
                written_q <= written_q + 1'b1;
            end
            if (accept) begin
                half_pending <= !half_pending;
                if (!half_pending) begin
                    low_q <= in_data;
                end
            end else if (push_flush) begin
                half_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_strb[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem_data[wptr] <= push_data;
                mem_strb[wptr] <= push_strb;
                wptr           <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_dla_ofmap_writer.sv
// Self-checking bench for dla_ofmap_writer: a per-cycle vector table for a basic
// job plus directed sequences for backpressure, flush, start/reset corners and random traffic.
module tb_dla_ofmap_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] num_words;
  logic        in_valid;
  logic [15:0] in_data;
  logic        flush;
  logic        stall;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_ack;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  dla_ofmap_writer #(.DEPTH(4), .ADDR_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .flush     (flush),
    .stall     (stall),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .wr_ack    (wr_ack),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // scoreboard: {addr[15:0], data[31:0], strb[3:0]}
  logic [51:0] exp_q[$];
  bit          mon_en = 1'b0;
  logic [15:0] m_base;
  logic [15:0] m_low;
  int          m_idx;
  bit          m_half;
  int          acc_cnt = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  bit          prev_hold = 1'b0;
  logic [51:0] prev_fields;

  typedef struct {
    logic        start;
    logic [15:0] base;
    logic [15:0] num;
    logic        iv;
    logic [15:0] din;
    logic        fl;
    logic        ack;
    logic        e_stall;
    logic        e_req;
    logic [15:0] e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_strb;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] s);
    logic [15:0] a;
    a = m_base + 16'(m_idx << 2);
    exp_q.push_back({a, d, s});
    m_idx++;
  endtask

  // One cycle: sample pre-edge at negedge+1, then advance to the next negedge.
  task automatic tick();
    logic [51:0] e;
    #1;
    if (mon_en) begin
      if (prev_hold) begin
        chk("req_hold", {63'd0, wr_req}, 64'd1);
        chk("fields_hold", {12'd0, wr_addr, wr_data, wr_strb}, {12'd0, prev_fields});
      end
      if (wr_req && wr_ack) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%0h expected=none", {wr_addr, wr_data, wr_strb});
        end else begin
          e = exp_q.pop_front();
          chk("write", {12'd0, wr_addr, wr_data, wr_strb}, {12'd0, e});
        end
      end
      if (in_valid && !stall) begin
        acc_cnt++;
        if (m_half) begin
          push_exp({in_data, m_low}, 4'hF);
          m_half = 1'b0;
        end else begin
          m_low  = in_data;
          m_half = 1'b1;
        end
      end
      if (done) done_cnt++;
      prev_hold   = wr_req && !wr_ack;
      prev_fields = {wr_addr, wr_data, wr_strb};
    end
    @(negedge clk);
  endtask

  task automatic job_start(input logic [15:0] b, input logic [15:0] n);
    start     = 1'b1;
    base_addr = b;
    num_words = n;
    in_valid  = 1'b0;
    m_base    = b;
    m_idx     = 0;
    m_half    = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) break;
      tick();
    end
    chk({name, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
    tick();
    chk({name, "_done_single"}, 64'(done_cnt - d0), 64'd1);
    chk({name, "_idle_after"}, {63'd0, busy}, 64'd0);
    chk({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    num_words = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    wr_ack    = 1'b0;

    // basic job, one row per cycle: base 0x100, 2 words, ack tied high
    vecs[0] = '{1'b1, 16'h0100, 16'd2, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'h0100, 16'd2, 1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'h0100, 16'd2, 1'b1, 16'h2222, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 16'h0100, 16'd2, 1'b1, 16'h3333, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0100, 32'h22221111, 4'hF, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 16'h0100, 16'd2, 1'b1, 16'h4444, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 16'h0100, 16'd2, 1'b1, 16'h5555, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0104, 32'h44443333, 4'hF, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 16'h0100, 16'd2, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 16'h0100, 16'd2, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_stall", {63'd0, stall}, 64'd1);
    chk("rst_wr_req", {63'd0, wr_req}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_fields", {12'd0, wr_addr, wr_data, wr_strb}, 64'd0);
    chk("rst_state", {62'd0, dbg_state}, 64'd0);
    @(negedge clk);

    // table-driven basic job
    for (int i = 0; i < 8; i++) begin
      start     = vecs[i].start;
      base_addr = vecs[i].base;
      num_words = vecs[i].num;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].din;
      flush     = vecs[i].fl;
      wr_ack    = vecs[i].ack;
      #1;
      chk($sformatf("vec%0d_stall", i), {63'd0, stall}, {63'd0, vecs[i].e_stall});
      chk($sformatf("vec%0d_req", i), {63'd0, wr_req}, {63'd0, vecs[i].e_req});
      chk($sformatf("vec%0d_busy", i), {63'd0, busy}, {63'd0, vecs[i].e_busy});
      chk($sformatf("vec%0d_done", i), {63'd0, done}, {63'd0, vecs[i].e_done});
      if (vecs[i].e_req) begin
        chk($sformatf("vec%0d_fields", i), {12'd0, wr_addr, wr_data, wr_strb},
            {12'd0, vecs[i].e_addr, vecs[i].e_data, vecs[i].e_strb});
      end
      @(negedge clk);
    end
    start    = 1'b0;
    in_valid = 1'b0;

    // backpressure: 8 words, ack low, continuous input
    mon_en  = 1'b1;
    wr_ack  = 1'b0;
    job_start(16'h0000, 16'd8);
    acc_cnt = 0;
    wr_cnt  = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 16'(acc_cnt + 1);
      tick();
    end
    chk("bp_accepted", 64'(acc_cnt), 64'd9);
    chk("bp_stall", {63'd0, stall}, 64'd1);
    chk("bp_head", {12'd0, wr_addr, wr_data, wr_strb}, {12'd0, 16'h0000, 32'h00020001, 4'hF});
    wr_ack = 1'b1;
    for (int i = 0; i < 60 && acc_cnt < 16; i++) begin
      in_data = 16'(acc_cnt + 1);
      tick();
    end
    in_valid = 1'b0;
    chk("bp_accepted_total", 64'(acc_cnt), 64'd16);
    wait_done("bp", 100);
    chk("bp_writes", 64'(wr_cnt), 64'd8);

    // flush of a lone halfword
    job_start(16'h0040, 16'd1);
    in_valid = 1'b1;
    in_data  = 16'hABCD;
    tick();
    in_valid = 1'b0;
    flush    = 1'b1;
    push_exp({16'h0000, m_low}, 4'b0011);
    m_half = 1'b0;
    tick();
    flush = 1'b0;
    wait_done("flush1", 20);

    // flush with nothing pending, flush colliding with a halfword, trailing flush
    job_start(16'h0080, 16'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_no_pending", {63'd0, wr_req}, 64'd0);
    in_valid = 1'b1;
    in_data  = 16'h1111;
    tick();
    in_data = 16'h2222;
    flush   = 1'b1;
    tick();
    flush   = 1'b0;
    in_data = 16'h3333;
    tick();
    in_valid = 1'b0;
    flush    = 1'b1;
    push_exp({16'h0000, m_low}, 4'b0011);
    m_half = 1'b0;
    tick();
    flush = 1'b0;
    wait_done("flush2", 20);

    // zero-length job
    job_start(16'h0200, 16'd0);
    chk("zero_done", {63'd0, done}, 64'd1);
    chk("zero_req", {63'd0, wr_req}, 64'd0);
    chk("zero_busy", {63'd0, busy}, 64'd0);
    tick();
    chk("zero_done_clear", {63'd0, done}, 64'd0);

    // start during RUN is ignored
    wr_cnt = 0;
    job_start(16'h0200, 16'd2);
    start     = 1'b1;
    base_addr = 16'h0300;
    num_words = 16'd5;
    in_valid  = 1'b1;
    in_data   = 16'hAAAA;
    tick();
    start = 1'b0;
    in_data = 16'hBBBB;
    tick();
    in_data = 16'hCCCC;
    tick();
    in_data = 16'hDDDD;
    tick();
    in_valid = 1'b0;
    wait_done("restart", 20);
    chk("restart_writes", 64'(wr_cnt), 64'd2);

    // asynchronous reset mid-job
    wr_ack = 1'b0;
    job_start(16'h0500, 16'd4);
    in_valid = 1'b1;
    in_data  = 16'h0001;
    tick();
    in_data = 16'h0002;
    tick();
    in_valid = 1'b0;
    chk("pre_reset_req", {63'd0, wr_req}, 64'd1);
    mon_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_stall", {63'd0, stall}, 64'd1);
    chk("midrst_req", {63'd0, wr_req}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_fields", {12'd0, wr_addr, wr_data, wr_strb}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    prev_hold = 1'b0;
    m_half    = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // random valid/ack over 64 words, address range wrapping past 0xFFFF
    acc_cnt = 0;
    wr_cnt  = 0;
    job_start(16'hFFC0, 16'd64);
    for (int i = 0; i < 3000 && acc_cnt < 128; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 16'($urandom_range(0, 65535));
      wr_ack   = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    chk("rand_accepted", 64'(acc_cnt), 64'd128);
    for (int i = 0; i < 40 && busy; i++) begin
      wr_ack = 1'($urandom_range(0, 1));
      tick();
    end
    wr_ack = 1'b1;
    wait_done("rand", 200);
    chk("rand_writes", 64'(wr_cnt), 64'd64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
